// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned FIFO_DEPTH    = 2;
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = 16;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t CntEmpty = 2'd0;
  localparam fifo_cnt_t CntOne   = 2'd1;
  localparam fifo_cnt_t CntFull  = fifo_cnt_t'(FIFO_DEPTH);

endpackage

// File: rtl/stream_demux_1to2_if.sv
// Bundle of the producer-side and both consumer-side stream signals plus debug counters.
interface stream_demux_1to2_if
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Environment side: producer and both consumers.
  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; the head is always entry 0 so head data comes straight from a flop.
module stream_fifo2
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  fifo_cnt_t        count_q, count_d;
  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic             push_ok, pop_ok;

  assign valid   = (count_q != CntEmpty);
  assign full    = (count_q == CntFull);
  assign head    = mem0_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  always_comb begin
    count_d = count_q;
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == CntEmpty) mem0_d = data;
        else                     mem1_d = data;
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        mem0_d  = mem1_q;
      end
      // Only reachable with one entry: the old head leaves, the new word becomes head.
      2'b11:   mem0_d = data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CntEmpty;
      mem0_q  <= '0;
      mem1_q  <= '0;
    end else begin
      count_q <= count_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux: steers each accepted word into a per-branch 2-entry FIFO.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  stream_demux_1to2_if.slave bus
);

  logic             live_q;
  logic             full0, full1;
  logic             accept, push0, push1, pop0, pop1;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Holds in_ready low while in reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  assign bus.in_ready = live_q && !(bus.in_sel ? full1 : full0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push0        = accept && !bus.in_sel;
  assign push1        = accept && bus.in_sel;
  assign pop0         = bus.out0_valid && bus.out0_ready;
  assign pop1         = bus.out1_valid && bus.out1_ready;

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .pop   (pop0),
    .data  (bus.in_data),
    .valid (bus.out0_valid),
    .full  (full0),
    .head  (bus.out0_data)
  );

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .pop   (pop1),
    .data  (bus.in_data),
    .valid (bus.out1_valid),
    .full  (full1),
    .head  (bus.out1_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (push0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (push1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed literal checks plus random traffic against a queue model.
module tb_stream_demux_1to2;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  stream_demux_1to2_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  stream_demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per branch, wrapping counters, ready gated by reset release.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] m_cnt0 = '0, m_cnt1 = '0;
  bit               alive = 0;
  bit               z0 = 1, z1 = 1;

  always @(negedge clk) begin
    bit exp_ready;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
      alive  = 0;
      z0     = 1;
      z1     = 1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_valid", {30'd0, bus.out1_valid, bus.out0_valid}, 32'd0);
      check("rst_data0", {24'd0, bus.out0_data}, 32'd0);
      check("rst_data1", {24'd0, bus.out1_data}, 32'd0);
      check("rst_cnt", {24'd0, bus.cnt1, bus.cnt0}, 32'd0);
    end else begin
      exp_ready = alive && ((bus.in_sel ? q1.size() : q0.size()) < 2);
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
      check("out0_valid", {31'd0, bus.out0_valid}, {31'd0, q0.size() != 0});
      check("out1_valid", {31'd0, bus.out1_valid}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) check("out0_data", {24'd0, bus.out0_data}, {24'd0, q0[0]});
      else if (z0)        check("out0_data_idle", {24'd0, bus.out0_data}, 32'd0);
      if (q1.size() != 0) check("out1_data", {24'd0, bus.out1_data}, {24'd0, q1[0]});
      else if (z1)        check("out1_data_idle", {24'd0, bus.out1_data}, 32'd0);
      check("cnt0", {28'd0, bus.cnt0}, {28'd0, m_cnt0});
      check("cnt1", {28'd0, bus.cnt1}, {28'd0, m_cnt1});
      // Predict what the next rising edge does.
      if (q0.size() != 0 && bus.out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && bus.out1_ready) void'(q1.pop_front());
      if (bus.in_valid && exp_ready) begin
        if (bus.in_sel) begin
          q1.push_back(bus.in_data);
          m_cnt1 = m_cnt1 + 1'b1;
          z1 = 0;
        end else begin
          q0.push_back(bus.in_data);
          m_cnt0 = m_cnt0 + 1'b1;
          z0 = 0;
        end
      end
      alive = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic v, input logic s, input logic [WIDTH-1:0] d,
                     input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    set(0, 0, 8'h00, 1, 1);
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    bit pend;
    set(0, 0, 8'h00, 0, 0);
    repeat (3) cyc();
    check("lit_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("lit_rst_valid0", {31'd0, bus.out0_valid}, 32'd0);
    check("lit_rst_cnt0", {28'd0, bus.cnt0}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check("lit_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    // Routing and latency.
    set(1, 0, 8'hA5, 1, 1);
    cyc();
    check("lit_route0_valid", {31'd0, bus.out0_valid}, 32'd1);
    check("lit_route0_data", {24'd0, bus.out0_data}, 32'hA5);
    check("lit_route0_cnt", {28'd0, bus.cnt0}, 32'd1);
    set(1, 1, 8'h3C, 1, 1);
    cyc();
    check("lit_route1_data", {24'd0, bus.out1_data}, 32'h3C);
    check("lit_route1_cnt", {28'd0, bus.cnt1}, 32'd1);
    check("lit_route0_popped", {31'd0, bus.out0_valid}, 32'd0);
    set(0, 0, 8'h00, 1, 1);
    cyc();

    // Backpressure on branch 0.
    set(1, 0, 8'h01, 0, 1);
    cyc();
    set(1, 0, 8'h02, 0, 1);
    cyc();
    set(1, 0, 8'h03, 0, 1);
    #1;
    check("lit_bp_full", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    check("lit_bp_head", {24'd0, bus.out0_data}, 32'h01);
    check("lit_bp_still_full", {31'd0, bus.in_ready}, 32'd0);
    set(1, 0, 8'h03, 1, 1);
    cyc();
    check("lit_bp_head2", {24'd0, bus.out0_data}, 32'h02);
    check("lit_bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    check("lit_bp_head3", {24'd0, bus.out0_data}, 32'h03);
    set(0, 0, 8'h00, 1, 1);
    cyc();
    check("lit_bp_drained", {31'd0, bus.out0_valid}, 32'd0);

    // Branch isolation.
    set(1, 0, 8'h55, 0, 1);
    cyc();
    set(1, 0, 8'h66, 0, 1);
    cyc();
    set(1, 1, 8'h77, 0, 0);
    #1;
    check("lit_iso_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    check("lit_iso_out1", {24'd0, bus.out1_data}, 32'h77);
    check("lit_iso_out0", {24'd0, bus.out0_data}, 32'h55);
    check("lit_iso_valid0", {31'd0, bus.out0_valid}, 32'd1);
    set(0, 0, 8'h00, 1, 1);
    repeat (3) cyc();

    // Reset mid-stream.
    set(1, 0, 8'hE1, 0, 1);
    cyc();
    set(1, 0, 8'hE2, 0, 1);
    cyc();
    set(0, 0, 8'h00, 0, 1);
    check("lit_mid_loaded", {31'd0, bus.out0_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("lit_mid_valid", {31'd0, bus.out0_valid}, 32'd0);
    check("lit_mid_cnt", {28'd0, bus.cnt0}, 32'd0);
    check("lit_mid_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("lit_mid_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("lit_mid_valid_after", {31'd0, bus.out0_valid}, 32'd0);

    // Simultaneous push/pop at one entry, full rate on branch 1.
    for (int i = 0; i < 16; i++) begin
      set(1, 1, 8'(8'h10 + i), 1, 1);
      #1;
      check("lit_pp_ready", {31'd0, bus.in_ready}, 32'd1);
      cyc();
      check("lit_pp_data", {24'd0, bus.out1_data}, 32'h10 + i);
    end
    set(0, 0, 8'h00, 1, 1);
    cyc();
    check("lit_pp_cnt_wrapped", {28'd0, bus.cnt1}, 32'd0);
    check("lit_pp_drained", {31'd0, bus.out1_valid}, 32'd0);

    // Counter wrap on a 4-bit counter.
    reset_pulse();
    for (int i = 1; i <= 17; i++) begin
      set(1, 0, 8'(i), 1, 1);
      cyc();
      if (i == 15) check("lit_wrap15", {28'd0, bus.cnt0}, 32'd15);
      if (i == 16) check("lit_wrap16", {28'd0, bus.cnt0}, 32'd0);
      if (i == 17) check("lit_wrap17", {28'd0, bus.cnt0}, 32'd1);
    end
    set(0, 0, 8'h00, 1, 1);
    cyc();

    // Random traffic; an unaccepted word is held stable.
    pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
        pend = 0;
      end
      if (!pend) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_sel   = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
      end
      bus.out0_ready = ($urandom_range(0, 2) != 0);
      bus.out1_ready = ($urandom_range(0, 3) == 0);
      #1;
      pend = bus.in_valid && !bus.in_ready;
      cyc();
    end

    set(0, 0, 8'h00, 1, 1);
    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
